h_5_inv: RTL and testbench

- Inverse of the H_5 permute/negate stage in the hybrid DSP core datapath.
- Takes the four 12-bit sign-magnitude lanes produced by H_5 and restores original lane order and sign:
  - I0 = O0
  - I1 = -O2
  - I2 = O1
  - I3 = -O3
- Adds a valid/ready handshake with a 2-stage elastic pipeline, so it can sit on the reconstruction (inverse-transform) path under back-pressure.

---
 rtl/h_stage_pkg.sv | 54 +++++
 rtl/h_pipe_reg.sv | 39 +++
 rtl/h_5_inv.sv | 89 ++++++++
 tb/tb_h_5_inv.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/h_stage_pkg.sv
// Shared types and helpers for the H_5 family of permute/negate stages.
// Samples are 12-bit sign-magnitude: bit W-1 is the sign, the rest the magnitude.
package h_stage_pkg;

    localparam int W        = 12;
    localparam int SIGN_BIT = W - 1;
    localparam int MAG_W    = W - 1;
    localparam int LANES    = 4;

    typedef logic [W-1:0] sample_t;

    typedef struct packed {
        sample_t d3;
        sample_t d2;
        sample_t d1;
        sample_t d0;
    } lanes_t;

    typedef struct packed {
        logic   bypass;
        lanes_t lanes;
    } beat_t;

    localparam int LANES_W = $bits(lanes_t);
    localparam int BEAT_W  = $bits(beat_t);

    // Sign flip only: zero becomes negative zero and back, so the stage stays an exact bit-inverse.
    function automatic sample_t neg(input sample_t x);
        return {~x[SIGN_BIT], x[SIGN_BIT-1:0]};
    endfunction

    function automatic logic sign_of(input sample_t x);
        return x[SIGN_BIT];
    endfunction

    function automatic logic [MAG_W-1:0] mag_of(input sample_t x);
        return x[MAG_W-1:0];
    endfunction

    // Undo H_5 (O0=I0, O1=I2, O2=-I1, O3=-I3); bypass passes lanes untouched.
    function automatic lanes_t lane_map_inv(input lanes_t o, input logic bypass);
        lanes_t r;
        if (bypass) begin
            r = o;
        end else begin
            r.d0 = o.d0;
            r.d1 = neg(o.d2);
            r.d2 = o.d1;
            r.d3 = neg(o.d3);
        end
        return r;
    endfunction

endpackage

// File: rtl/h_pipe_reg.sv
// One-stage valid/ready register slice; holds a single beat and accepts a new one
// whenever it is empty or its current beat leaves in the same cycle.
module h_pipe_reg #(
    parameter int DW = 49
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [DW-1:0] IN_DATA,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [DW-1:0] OUT_DATA
);

    // A beat moves across an interface on a rising edge where VALID & READY are both 1;
    // VALID never depends on READY, and READY here depends only on local state and OUT_READY.
    logic          v;
    logic [DW-1:0] data;

    assign IN_READY  = !v || OUT_READY;
    assign OUT_VALID = v;
    assign OUT_DATA  = data;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            v    <= 1'b0;
            data <= '0;
        end else begin
            if (IN_READY) begin
                v <= IN_VALID;
            end
            if (IN_VALID && IN_READY) begin
                data <= IN_DATA;
            end
        end
    end

endmodule

// File: rtl/h_5_inv.sv
// Inverse of the H_5 permute/negate stage: restores lane order and sign behind a
// two-register elastic pipeline, with a per-beat bypass and an output beat counter.
module h_5_inv
    import h_stage_pkg::*;
#(
    parameter int W     = h_stage_pkg::W,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [W-1:0]     D0,
    input  logic [W-1:0]     D1,
    input  logic [W-1:0]     D2,
    input  logic [W-1:0]     D3,
    input  logic             BYPASS,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [W-1:0]     Q0,
    output logic [W-1:0]     Q1,
    output logic [W-1:0]     Q2,
    output logic [W-1:0]     Q3,
    output logic [CNT_W-1:0] BEAT_CNT
);

    beat_t  in_beat;
    beat_t  s1_beat;
    lanes_t s2_in_lanes;
    lanes_t s2_lanes;
    logic   s1_v;
    logic   s2_v;
    logic   adv2;

    always_comb begin
        in_beat          = '0;
        in_beat.bypass   = BYPASS;
        in_beat.lanes.d0 = D0;
        in_beat.lanes.d1 = D1;
        in_beat.lanes.d2 = D2;
        in_beat.lanes.d3 = D3;
    end

    h_pipe_reg #(
        .DW (BEAT_W)
    ) u_s1 (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_DATA   (in_beat),
        .OUT_VALID (s1_v),
        .OUT_READY (adv2),
        .OUT_DATA  (s1_beat)
    );

    // The bypass flag is consumed here, so stage 2 only carries the mapped lanes.
    always_comb begin
        s2_in_lanes = lane_map_inv(s1_beat.lanes, s1_beat.bypass);
    end

    h_pipe_reg #(
        .DW (LANES_W)
    ) u_s2 (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_VALID  (s1_v),
        .IN_READY  (adv2),
        .IN_DATA   (s2_in_lanes),
        .OUT_VALID (s2_v),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (s2_lanes)
    );

    assign OUT_VALID = s2_v;
    assign Q0        = s2_lanes.d0;
    assign Q1        = s2_lanes.d1;
    assign Q2        = s2_lanes.d2;
    assign Q3        = s2_lanes.d3;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            BEAT_CNT <= '0;
        end else if (s2_v && OUT_READY) begin
            BEAT_CNT <= BEAT_CNT + 1'b1;
        end
    end

endmodule

// File: tb/tb_h_5_inv.sv
// Randomized bench for h_5_inv against a round-trip / lane-map model with an expected queue.
module tb_h_5_inv;

  localparam int W = 12;
  localparam int CNT_W = 4;
  localparam logic [W-1:0] SIGN_MASK = 12'h800;

  logic CLK;
  logic RESET;
  logic IN_VALID;
  logic IN_READY;
  logic [W-1:0] D0, D1, D2, D3;
  logic BYPASS;
  logic OUT_VALID;
  logic OUT_READY;
  logic [W-1:0] Q0, Q1, Q2, Q3;
  logic [CNT_W-1:0] BEAT_CNT;

  int tests = 0;
  int fails = 0;
  int cnt_model = 0;
  logic [4*W-1:0] exp_q[$];

  logic s_in_acc, s_out_acc, s_out_v, s_in_rdy;
  logic [4*W-1:0] s_q;
  logic [CNT_W-1:0] s_cnt;

  h_5_inv #(.W(W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3), .BYPASS(BYPASS),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3), .BEAT_CNT(BEAT_CNT)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // reference model
  function automatic logic [W-1:0] neg_m(input logic [W-1:0] x);
    return x ^ SIGN_MASK;
  endfunction

  // forward H_5 on packed {I3,I2,I1,I0}: O0=I0, O1=I2, O2=-I1, O3=-I3
  function automatic logic [4*W-1:0] h5_fwd(input logic [4*W-1:0] i);
    logic [W-1:0] i0, i1, i2, i3;
    {i3, i2, i1, i0} = i;
    return {neg_m(i3), neg_m(i1), i2, i0};
  endfunction

  function automatic logic [4*W-1:0] inv_model(input logic [4*W-1:0] d, input logic byp);
    logic [W-1:0] d0, d1, d2, d3;
    {d3, d2, d1, d0} = d;
    if (byp) return d;
    return {neg_m(d3), d1, neg_m(d2), d0};
  endfunction

  function automatic logic [4*W-1:0] rand_lanes();
    return {12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom)};
  endfunction

  // driver: apply inputs for one cycle, sample outputs on the falling edge
  task automatic step(input logic iv, input logic [4*W-1:0] d, input logic byp, input logic ordy);
    IN_VALID = iv;
    {D3, D2, D1, D0} = d;
    BYPASS = byp;
    OUT_READY = ordy;
    @(negedge CLK);
    s_in_rdy  = IN_READY;
    s_in_acc  = iv & IN_READY;
    s_out_v   = OUT_VALID;
    s_out_acc = OUT_VALID & ordy;
    s_q       = {Q3, Q2, Q1, Q0};
    s_cnt     = BEAT_CNT;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    step(1'b1, rand_lanes(), 1'b0, 1'b1);
    step(1'b1, rand_lanes(), 1'b0, 1'b1);
    RESET = 1'b0;
    exp_q.delete();
    cnt_model = 0;
    step(1'b0, '0, 1'b0, 1'b1);
    tests++; if (s_out_v !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", s_out_v); end
    tests++; if (s_q !== '0) begin fails++; $display("FAIL reset_q: got %h expected 0", s_q); end
    tests++; if (s_cnt !== '0) begin fails++; $display("FAIL reset_beat_cnt: got %0d expected 0", s_cnt); end
    tests++; if (s_in_rdy !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", s_in_rdy); end
  endtask

  task automatic test_directed();
    logic [4*W-1:0] vec_d [2];
    logic [4*W-1:0] vec_q [2];
    int found;
    vec_d[0] = {12'h007, 12'h805, 12'h456, 12'h123};
    vec_q[0] = {12'h807, 12'h456, 12'h005, 12'h123};
    vec_d[1] = {12'h800, 12'h000, 12'h7FF, 12'h3A5};
    vec_q[1] = {12'h000, 12'h7FF, 12'h800, 12'h3A5};
    for (int v = 0; v < 2; v++) begin
      step(1'b1, vec_d[v], 1'b0, 1'b1);
      tests++; if (s_in_acc !== 1'b1) begin fails++; $display("FAIL directed_accept[%0d]: got %b expected 1", v, s_in_acc); end
      found = -1;
      for (int k = 1; k <= 6 && found < 0; k++) begin
        step(1'b0, '0, 1'b0, 1'b1);
        if (s_out_acc) begin
          found = k;
          cnt_model++;
          tests++; if (s_q !== vec_q[v]) begin fails++; $display("FAIL directed_q[%0d]: got %h expected %h", v, s_q, vec_q[v]); end
        end
      end
      tests++; if (found != 2) begin fails++; $display("FAIL directed_latency[%0d]: got %0d expected 2", v, found); end
      step(1'b0, '0, 1'b0, 1'b1);
      tests++; if (s_cnt !== CNT_W'(cnt_model)) begin fails++; $display("FAIL directed_cnt[%0d]: got %0d expected %0d", v, s_cnt, CNT_W'(cnt_model)); end
    end
  endtask

  task automatic test_round_trip();
    int sent = 0, got = 0, pre, bad = 0;
    logic iv, ordy;
    logic [4*W-1:0] i;
    for (int c = 0; c < 6000 && got < 1000; c++) begin
      iv = (sent < 1000) && ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      i = rand_lanes();
      pre = exp_q.size();
      step(iv, h5_fwd(i), 1'b0, ordy);
      if (s_in_rdy !== ((pre < 2) || ordy)) begin
        bad++;
        if (bad < 5) $display("FAIL rt_in_ready: got %b expected %b (cycle %0d)", s_in_rdy, (pre < 2) || ordy, c);
      end
      if (s_out_acc) begin
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL rt_extra_beat: got %h expected none", s_q); end
        else begin
          if (s_q !== exp_q[0]) begin fails++; $display("FAIL rt_data: got %h expected %h", s_q, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        got++;
        cnt_model++;
      end
      if (s_in_acc) begin exp_q.push_back(i); sent++; end
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL rt_in_ready_total: got %0d wrong cycles expected 0", bad); end
    tests++; if (got != 1000) begin fails++; $display("FAIL rt_delivered: got %0d expected 1000", got); end
    step(1'b0, '0, 1'b0, 1'b1);
    tests++; if (s_cnt !== CNT_W'(cnt_model)) begin fails++; $display("FAIL rt_cnt: got %0d expected %0d", s_cnt, CNT_W'(cnt_model)); end
  endtask

  task automatic test_back_pressure();
    int sent = 0, got = 0, pre, stall_seen = 0;
    logic ordy, prev_hold = 1'b0;
    logic [4*W-1:0] d, prev_q = '0;
    logic byp;
    for (int c = 0; c < 60 && got < 10; c++) begin
      ordy = !(c >= 3 && c <= 6);
      d = rand_lanes();
      byp = 1'($urandom_range(0, 1));
      pre = exp_q.size();
      step(sent < 10, d, byp, ordy);
      tests++;
      if (s_in_rdy !== ((pre < 2) || ordy)) begin fails++; $display("FAIL bp_in_ready: got %b expected %b (cycle %0d)", s_in_rdy, (pre < 2) || ordy, c); end
      if (!s_in_rdy) stall_seen++;
      if (prev_hold) begin
        tests++; if (s_q !== prev_q) begin fails++; $display("FAIL bp_q_stable: got %h expected %h", s_q, prev_q); end
      end
      prev_hold = s_out_v && !ordy;
      prev_q = s_q;
      if (s_out_acc) begin
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL bp_extra_beat: got %h expected none", s_q); end
        else begin
          if (s_q !== exp_q[0]) begin fails++; $display("FAIL bp_data: got %h expected %h", s_q, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        got++;
        cnt_model++;
      end
      if (s_in_acc) begin exp_q.push_back(inv_model(d, byp)); sent++; end
    end
    tests++; if (stall_seen == 0) begin fails++; $display("FAIL bp_stall_seen: got 0 not-ready cycles expected >0"); end
    tests++; if (got != 10) begin fails++; $display("FAIL bp_delivered: got %0d expected 10", got); end
    step(1'b0, '0, 1'b0, 1'b1);
    tests++; if (s_cnt !== CNT_W'(cnt_model)) begin fails++; $display("FAIL bp_cnt: got %0d expected %0d", s_cnt, CNT_W'(cnt_model)); end
  endtask

  task automatic test_bypass_wrap();
    int total, sent = 0, got = 0;
    logic [4*W-1:0] d, last_d;
    logic byp;
    last_d = {12'h333, 12'h222, 12'h111, 12'hABC};
    total = ((1 << CNT_W) - 1 - (cnt_model % (1 << CNT_W))) + 1;
    for (int c = 0; c < 200 && got < total; c++) begin
      if (sent == total - 1) begin d = last_d; byp = 1'b1; end
      else begin d = rand_lanes(); byp = 1'($urandom_range(0, 1)); end
      step(sent < total, d, byp, 1'b1);
      if (s_out_acc) begin
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL wrap_extra_beat: got %h expected none", s_q); end
        else begin
          if (s_q !== exp_q[0]) begin fails++; $display("FAIL wrap_data: got %h expected %h", s_q, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        got++;
        cnt_model++;
        if (got == total) begin
          tests++; if (s_q !== last_d) begin fails++; $display("FAIL wrap_bypass_q: got %h expected %h", s_q, last_d); end
        end
      end
      if (s_in_acc) begin exp_q.push_back(inv_model(d, byp)); sent++; end
    end
    tests++; if (got != total) begin fails++; $display("FAIL wrap_delivered: got %0d expected %0d", got, total); end
    step(1'b0, '0, 1'b0, 1'b1);
    tests++; if (s_cnt !== '0) begin fails++; $display("FAIL wrap_cnt_zero: got %0d expected 0", s_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    int stale = 0;
    for (int c = 0; c < 6 && exp_q.size() < 2; c++) begin
      step(1'b1, rand_lanes(), 1'b0, 1'b0);
      if (s_in_acc) exp_q.push_back('0);
    end
    tests++; if (exp_q.size() != 2) begin fails++; $display("FAIL mid_fill: got %0d beats expected 2", exp_q.size()); end
    RESET = 1'b1;
    step(1'b1, rand_lanes(), 1'b0, 1'b0);
    RESET = 1'b0;
    exp_q.delete();
    cnt_model = 0;
    step(1'b0, '0, 1'b0, 1'b1);
    tests++; if (s_out_v !== 1'b0) begin fails++; $display("FAIL mid_out_valid: got %b expected 0", s_out_v); end
    tests++; if (s_cnt !== '0) begin fails++; $display("FAIL mid_cnt: got %0d expected 0", s_cnt); end
    tests++; if (s_in_rdy !== 1'b1) begin fails++; $display("FAIL mid_in_ready: got %b expected 1", s_in_rdy); end
    for (int c = 0; c < 5; c++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      if (s_out_v) stale++;
    end
    tests++; if (stale != 0) begin fails++; $display("FAIL mid_stale_beat: got %0d valid cycles expected 0", stale); end
  endtask

  initial begin
    RESET = 1'b1;
    IN_VALID = 1'b0;
    BYPASS = 1'b0;
    OUT_READY = 1'b1;
    {D3, D2, D1, D0} = '0;
    test_reset();
    test_directed();
    test_round_trip();
    test_back_pressure();
    test_bypass_wrap();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
